// File: rtl/accelerator_tensor_matrix_product_engine_pkg.sv
// Shared definitions for the tensor-by-matrix product engine: FSM state
// encoding, single-bit constants, index-width helper and the saturating
// narrowing used on the accumulator output.
package accelerator_tensor_matrix_product_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic ZERO = 1'b0;
  localparam logic ONE  = 1'b1;

  // Bits needed to index n entries (at least one bit).
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Clamp a signed value into the range of a signed 'width'-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (width - 1));
    if (value > max_v) return max_v;
    else if (value < min_v) return min_v;
    else return value;
  endfunction

endpackage

// File: rtl/accelerator_tensor_matrix_product_engine_mac.sv
// Signed multiply-accumulate for the product engine. The accumulator keeps
// full precision; result_next is the value the accumulator would hold after
// this cycle's product, rescaled by FRACTION_SIZE and saturated to DATA_SIZE,
// so the caller can register the finished element on the last k cycle.
module accelerator_tensor_mac
  import accelerator_tensor_matrix_product_engine_pkg::*;
#(
  parameter int DATA_SIZE     = 16,
  parameter int FRACTION_SIZE = 8,
  parameter int MAX_K         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [DATA_SIZE-1:0] op_a,
  input  logic [DATA_SIZE-1:0] op_b,
  output logic [DATA_SIZE-1:0] result_next
);

  localparam int PROD_W = 2 * DATA_SIZE;
  localparam int ACC_W  = PROD_W + idx_width(MAX_K);

  logic signed [PROD_W-1:0] product;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [ACC_W-1:0]  shifted;

  // Full-precision product, running sum and rescaled/saturated view of it.
  always_comb begin
    product     = PROD_W'($signed(op_a)) * PROD_W'($signed(op_b));
    acc_next    = acc + ACC_W'(product);
    shifted     = acc_next >>> FRACTION_SIZE;
    result_next = DATA_SIZE'(saturate(64'(shifted), DATA_SIZE));
  end

  // Accumulator: clear has priority so every element starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      acc <= '0;
    else if (clear)  acc <= '0;
    else if (enable) acc <= acc_next;
  end

endmodule

// File: rtl/accelerator_tensor_matrix_product_engine.sv
// Tensor-by-matrix product engine: C[i][j][l] = sum_k A[i][j][k] * B[k][l].
// A (i,j,k order) and B (k,l order) are streamed into local buffers, then one
// MAC produces C serially in i,j,l order with wrap markers.
//
// Handshake: START is a one-cycle request sampled only in IDLE; sizes are
// captured on that cycle. DATA_*_IN_ENABLE are plain valid strobes with no
// backpressure: an element is taken on every enabled cycle in LOAD until its
// buffer is full, later strobes are dropped. DATA_OUT_ENABLE marks the single
// cycle on which DATA_OUT and the I/J/K markers describe a new C element.
module accelerator_tensor_matrix_product_engine
  import accelerator_tensor_matrix_product_engine_pkg::*;
#(
  parameter int DATA_SIZE     = 16,
  parameter int FRACTION_SIZE = 8,
  parameter int MAX_I         = 4,
  parameter int MAX_J         = 4,
  parameter int MAX_K         = 4,
  parameter int MAX_L         = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0] SIZE_L_IN,
  input  logic                 DATA_A_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_A_IN,
  input  logic                 DATA_B_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] DATA_B_IN,
  output logic                 DATA_OUT_ENABLE,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic [2:0]           fsm_state
);

  localparam int A_DEPTH = MAX_I * MAX_J * MAX_K;
  localparam int B_DEPTH = MAX_K * MAX_L;
  localparam int AAW     = idx_width(A_DEPTH);
  localparam int BAW     = idx_width(B_DEPTH);
  localparam int CW      = idx_width(A_DEPTH + B_DEPTH + 1);

  state_t state;

  logic [CW-1:0] size_i, size_j, size_k, size_l;
  logic [CW-1:0] a_cnt, b_cnt, a_cnt_next, b_cnt_next, a_total, b_total;
  logic [CW-1:0] i_cnt, j_cnt, k_cnt, l_cnt;
  logic [AAW-1:0] a_idx;
  logic [BAW-1:0] b_idx;
  logic a_wr, b_wr, load_done, size_ok;
  logic i_last, j_last, k_last, l_last;
  logic [DATA_SIZE-1:0] op_a, op_b, mac_result;
  logic mac_clear, mac_enable;

  logic [DATA_SIZE-1:0] a_mem [0:(1<<AAW)-1];
  logic [DATA_SIZE-1:0] b_mem [0:(1<<BAW)-1];

  // Size validation, buffer fill bookkeeping, operand addressing and wrap flags.
  always_comb begin
    size_ok = (SIZE_I_IN != '0) && (SIZE_I_IN <= DATA_SIZE'(MAX_I)) &&
              (SIZE_J_IN != '0) && (SIZE_J_IN <= DATA_SIZE'(MAX_J)) &&
              (SIZE_K_IN != '0) && (SIZE_K_IN <= DATA_SIZE'(MAX_K)) &&
              (SIZE_L_IN != '0) && (SIZE_L_IN <= DATA_SIZE'(MAX_L));
    a_total    = size_i * size_j * size_k;
    b_total    = size_k * size_l;
    a_wr       = (state == ST_LOAD) && DATA_A_IN_ENABLE && (a_cnt < a_total);
    b_wr       = (state == ST_LOAD) && DATA_B_IN_ENABLE && (b_cnt < b_total);
    a_cnt_next = a_cnt + CW'(a_wr);
    b_cnt_next = b_cnt + CW'(b_wr);
    load_done  = (a_cnt_next == a_total) && (b_cnt_next == b_total);
    a_idx      = AAW'((i_cnt * size_j + j_cnt) * size_k + k_cnt);
    b_idx      = BAW'(k_cnt * size_l + l_cnt);
    op_a       = a_mem[a_idx];
    op_b       = b_mem[b_idx];
    i_last     = (i_cnt == size_i - CW'(1));
    j_last     = (j_cnt == size_j - CW'(1));
    k_last     = (k_cnt == size_k - CW'(1));
    l_last     = (l_cnt == size_l - CW'(1));
    mac_clear  = (state != ST_COMPUTE);
    mac_enable = (state == ST_COMPUTE);
    fsm_state  = state;
  end

  // Operand buffers; contents are meaningless until loaded, so no reset.
  always_ff @(posedge CLK) begin
    if (a_wr) a_mem[AAW'(a_cnt)] <= DATA_A_IN;
    if (b_wr) b_mem[BAW'(b_cnt)] <= DATA_B_IN;
  end

  accelerator_tensor_mac #(
    .DATA_SIZE     (DATA_SIZE),
    .FRACTION_SIZE (FRACTION_SIZE),
    .MAX_K         (MAX_K)
  ) u_mac (
    .clk         (CLK),
    .rst_n       (RST),
    .clear       (mac_clear),
    .enable      (mac_enable),
    .op_a        (op_a),
    .op_b        (op_b),
    .result_next (mac_result)
  );

  // Control FSM with registered pulse outputs and index counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state             <= ST_IDLE;
      READY             <= ZERO;
      ERROR             <= ZERO;
      DATA_OUT_ENABLE   <= ZERO;
      DATA_OUT_I_ENABLE <= ZERO;
      DATA_OUT_J_ENABLE <= ZERO;
      DATA_OUT_K_ENABLE <= ZERO;
      DATA_OUT          <= '0;
      size_i <= '0; size_j <= '0; size_k <= '0; size_l <= '0;
      a_cnt  <= '0; b_cnt  <= '0;
      i_cnt  <= '0; j_cnt  <= '0; k_cnt  <= '0; l_cnt  <= '0;
    end else begin
      READY             <= ZERO;
      ERROR             <= ZERO;
      DATA_OUT_ENABLE   <= ZERO;
      DATA_OUT_I_ENABLE <= ZERO;
      DATA_OUT_J_ENABLE <= ZERO;
      DATA_OUT_K_ENABLE <= ZERO;
      case (state)
        ST_IDLE: begin
          if (START) begin
            if (size_ok) begin
              size_i <= CW'(SIZE_I_IN);
              size_j <= CW'(SIZE_J_IN);
              size_k <= CW'(SIZE_K_IN);
              size_l <= CW'(SIZE_L_IN);
              a_cnt  <= '0; b_cnt <= '0;
              i_cnt  <= '0; j_cnt <= '0; k_cnt <= '0; l_cnt <= '0;
              state  <= ST_LOAD;
            end else begin
              ERROR <= ONE;
            end
          end
        end
        ST_LOAD: begin
          a_cnt <= a_cnt_next;
          b_cnt <= b_cnt_next;
          if (load_done) state <= ST_COMPUTE;
        end
        ST_COMPUTE: begin
          if (k_last) begin
            k_cnt             <= '0;
            DATA_OUT          <= mac_result;
            DATA_OUT_ENABLE   <= ONE;
            DATA_OUT_K_ENABLE <= l_last;
            DATA_OUT_J_ENABLE <= l_last && j_last;
            DATA_OUT_I_ENABLE <= l_last && j_last && i_last;
            state             <= ST_OUTPUT;
          end else begin
            k_cnt <= k_cnt + CW'(1);
          end
        end
        ST_OUTPUT: begin
          if (!l_last) begin
            l_cnt <= l_cnt + CW'(1);
            state <= ST_COMPUTE;
          end else begin
            l_cnt <= '0;
            if (!j_last) begin
              j_cnt <= j_cnt + CW'(1);
              state <= ST_COMPUTE;
            end else begin
              j_cnt <= '0;
              if (!i_last) begin
                i_cnt <= i_cnt + CW'(1);
                state <= ST_COMPUTE;
              end else begin
                i_cnt <= '0;
                READY <= ONE;
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accelerator_tensor_matrix_product_engine.sv
// Self-checking bench for the tensor-by-matrix product engine.
module tb_accelerator_tensor_matrix_product_engine;

  localparam int DW = 16;
  localparam int EW = DW + 3;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START = 1'b0;
  logic          READY, ERROR;
  logic [DW-1:0] SIZE_I_IN = '0, SIZE_J_IN = '0, SIZE_K_IN = '0, SIZE_L_IN = '0;
  logic          DATA_A_IN_ENABLE = 1'b0, DATA_B_IN_ENABLE = 1'b0;
  logic [DW-1:0] DATA_A_IN = '0, DATA_B_IN = '0;
  logic          DATA_OUT_ENABLE, DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE;
  logic [DW-1:0] DATA_OUT;
  logic [2:0]    fsm_state;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int error_cnt = 0;
  int out_cnt = 0;

  logic [EW-1:0] exp_q[$];
  logic signed [DW-1:0] a_v [64];
  logic signed [DW-1:0] b_v [16];

  accelerator_tensor_matrix_product_engine dut (
    .CLK               (CLK),
    .RST               (RST),
    .START             (START),
    .READY             (READY),
    .ERROR             (ERROR),
    .SIZE_I_IN         (SIZE_I_IN),
    .SIZE_J_IN         (SIZE_J_IN),
    .SIZE_K_IN         (SIZE_K_IN),
    .SIZE_L_IN         (SIZE_L_IN),
    .DATA_A_IN_ENABLE  (DATA_A_IN_ENABLE),
    .DATA_A_IN         (DATA_A_IN),
    .DATA_B_IN_ENABLE  (DATA_B_IN_ENABLE),
    .DATA_B_IN         (DATA_B_IN),
    .DATA_OUT_ENABLE   (DATA_OUT_ENABLE),
    .DATA_OUT_I_ENABLE (DATA_OUT_I_ENABLE),
    .DATA_OUT_J_ENABLE (DATA_OUT_J_ENABLE),
    .DATA_OUT_K_ENABLE (DATA_OUT_K_ENABLE),
    .DATA_OUT          (DATA_OUT),
    .fsm_state         (fsm_state)
  );

  // Clock and watchdog.
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  // Reference: one C element from plain integer arithmetic.
  function automatic logic [DW-1:0] model_elem(input int i, input int j, input int l,
                                               input int sj, input int sk, input int sl);
    longint acc;
    longint res;
    acc = 0;
    for (int k = 0; k < sk; k++)
      acc += longint'(a_v[(i * sj + j) * sk + k]) * longint'(b_v[k * sl + l]);
    res = acc >>> 8;
    if (res > 32767) res = 32767;
    else if (res < -32768) res = -32768;
    return res[DW-1:0];
  endfunction

  task automatic push_model(input int si, input int sj, input int sk, input int sl);
    logic km, jm, im;
    for (int i = 0; i < si; i++)
      for (int j = 0; j < sj; j++)
        for (int l = 0; l < sl; l++) begin
          km = (l == sl - 1);
          jm = km && (j == sj - 1);
          im = jm && (i == si - 1);
          exp_q.push_back({im, jm, km, model_elem(i, j, l, sj, sk, sl)});
        end
  endtask

  // Scoreboard compare: every valid output against the head of the queue.
  always @(negedge CLK) begin
    logic [EW-1:0] exp_e;
    logic [EW-1:0] got_e;
    if (RST) begin
      if (READY) ready_cnt++;
      if (ERROR) error_cnt++;
      if (DATA_OUT_ENABLE) begin
        out_cnt++;
        checks++;
        got_e = {DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE, DATA_OUT};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out got %h want none", got_e);
        end else begin
          exp_e = exp_q.pop_front();
          if (got_e !== exp_e) begin
            errors++;
            $display("FAIL out_elem got ijk=%b data=%h want ijk=%b data=%h",
                     got_e[EW-1:DW], got_e[DW-1:0], exp_e[EW-1:DW], exp_e[DW-1:0]);
          end
        end
      end else if (DATA_OUT_I_ENABLE || DATA_OUT_J_ENABLE || DATA_OUT_K_ENABLE) begin
        checks++;
        errors++;
        $display("FAIL marker_idle got ijk=%b want 000",
                 {DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE});
      end
    end
  end

  // Driver: one-cycle START with sizes; returns on the following negedge.
  task automatic start_op(input int si, input int sj, input int sk, input int sl);
    @(negedge CLK);
    START = 1'b1;
    SIZE_I_IN = DW'(si); SIZE_J_IN = DW'(sj); SIZE_K_IN = DW'(sk); SIZE_L_IN = DW'(sl);
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Driver: stream A and B; returns at the first negedge after the last write.
  task automatic load_data(input int si, input int sj, input int sk, input int sl,
                           input bit gaps, input bit extras);
    int na, nb, a_sent, b_sent;
    bit a_go, b_go;
    na = si * sj * sk;
    nb = sk * sl;
    a_sent = 0;
    b_sent = 0;
    while (a_sent < na || b_sent < nb) begin
      a_go = (a_sent < na) && (!gaps || $urandom_range(0, 1) == 1);
      b_go = (b_sent < nb) && (!gaps || $urandom_range(0, 1) == 1);
      if (a_go) begin
        DATA_A_IN_ENABLE = 1'b1; DATA_A_IN = a_v[a_sent]; a_sent++;
      end else begin
        DATA_A_IN_ENABLE = extras && (a_sent >= na) && ($urandom_range(0, 1) == 1);
        DATA_A_IN = DW'($urandom);
      end
      if (b_go) begin
        DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = b_v[b_sent]; b_sent++;
      end else begin
        DATA_B_IN_ENABLE = extras && (b_sent >= nb) && ($urandom_range(0, 1) == 1);
        DATA_B_IN = DW'($urandom);
      end
      @(negedge CLK);
    end
    DATA_A_IN_ENABLE = 1'b0;
    DATA_B_IN_ENABLE = 1'b0;
  endtask

  // Wait for READY counting cycles from the first cycle after loading.
  task automatic wait_done(input int total);
    int n;
    n = 1;
    while (READY !== 1'b1 && n < total + 50) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (READY !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %0d cycles want %0d", n, total);
    end else begin
      check_int("latency", n, total);
    end
    check_int("pending_outputs", exp_q.size(), 0);
    @(negedge CLK);
    check_val("ready_pulse_low", DW'(READY), '0);
  endtask

  task automatic fill_random(input bit full_range, input bit positive);
    for (int x = 0; x < 64; x++)
      a_v[x] = full_range ? DW'($urandom) :
               positive   ? DW'($urandom_range(128, 1024)) :
                            DW'(int'($urandom_range(0, 2047)) - 1024);
    for (int x = 0; x < 16; x++)
      b_v[x] = full_range ? DW'($urandom) :
               positive   ? DW'($urandom_range(128, 1024)) :
                            DW'(int'($urandom_range(0, 2047)) - 1024);
  endtask

  task automatic run_case(input int si, input int sj, input int sk, input int sl,
                          input bit gaps, input bit extras);
    start_op(si, sj, sk, sl);
    push_model(si, sj, sk, sl);
    load_data(si, sj, sk, sl, gaps, extras);
    wait_done(si * sj * sl * (sk + 1) + 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_ready"}, DW'(READY), '0);
    check_val({tag, "_error"}, DW'(ERROR), '0);
    check_val({tag, "_out_en"}, DW'(DATA_OUT_ENABLE), '0);
    check_val({tag, "_markers"},
              DW'({DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE}), '0);
    check_val({tag, "_data"}, DATA_OUT, '0);
  endtask

  // Test sequence.
  initial begin
    int rc, ec, oc;
    repeat (3) @(negedge CLK);
    check_outputs_zero("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Single element, all markers together.
    a_v[0] = 16'h0200; b_v[0] = 16'h0180;
    check_val("model_pin_1x1", model_elem(0, 0, 0, 1, 1, 1), 16'h0300);
    run_case(1, 1, 1, 1, 1'b0, 1'b0);

    // K=L=2 row, A and B streamed together.
    a_v[0] = 16'h0100; a_v[1] = 16'h0200;
    b_v[0] = 16'h0100; b_v[1] = 16'h0200; b_v[2] = 16'h0300; b_v[3] = 16'h0400;
    check_val("model_pin_l0", model_elem(0, 0, 0, 1, 2, 2), 16'h0700);
    check_val("model_pin_l1", model_elem(0, 0, 1, 1, 2, 2), 16'h0A00);
    run_case(1, 1, 2, 2, 1'b0, 1'b0);

    // Saturation at both ends.
    a_v[0] = 16'h7F00; b_v[0] = 16'h7F00;
    check_val("model_pin_sat_hi", model_elem(0, 0, 0, 1, 1, 1), 16'h7FFF);
    run_case(1, 1, 1, 1, 1'b0, 1'b0);
    a_v[0] = 16'h8000; b_v[0] = 16'h7F00;
    check_val("model_pin_sat_lo", model_elem(0, 0, 0, 1, 1, 1), 16'h8000);
    run_case(1, 1, 1, 1, 1'b0, 1'b0);

    // Illegal sizes: ERROR pulse, nothing else.
    rc = ready_cnt; ec = error_cnt; oc = out_cnt;
    start_op(1, 1, 0, 1);
    check_val("error_k0", DW'(ERROR), 16'h0001);
    @(negedge CLK);
    check_val("error_k0_low", DW'(ERROR), '0);
    repeat (3) @(negedge CLK);
    start_op(1, 1, 1, 5);
    check_val("error_l5", DW'(ERROR), 16'h0001);
    repeat (4) @(negedge CLK);
    check_int("error_count", error_cnt - ec, 2);
    check_int("error_no_ready", ready_cnt - rc, 0);
    check_int("error_no_output", out_cnt - oc, 0);
    fill_random(1'b0, 1'b0);
    run_case(1, 2, 1, 1, 1'b0, 1'b0);

    // Reset during COMPUTE of the third element of a 2x2x2x2 run.
    fill_random(1'b0, 1'b1);
    start_op(2, 2, 2, 2);
    push_model(2, 2, 2, 2);
    load_data(2, 2, 2, 2, 1'b0, 1'b0);
    repeat (6) @(negedge CLK);
    check_int("pre_reset_outputs", 8 - exp_q.size(), 2);
    RST = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    fill_random(1'b0, 1'b0);
    run_case(2, 2, 2, 2, 1'b0, 1'b0);

    // Full-size runs with gaps and surplus enables.
    fill_random(1'b1, 1'b0);
    run_case(4, 4, 4, 4, 1'b1, 1'b1);
    fill_random(1'b0, 1'b0);
    run_case(4, 4, 4, 4, 1'b1, 1'b1);

    // Random sizes.
    for (int t = 0; t < 4; t++) begin
      fill_random(t[0], 1'b0);
      run_case($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4),
               $urandom_range(1, 4), 1'b1, 1'b1);
    end

    repeat (2) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accelerator_tensor_matrix_product_engine.md
Name: accelerator_tensor_matrix_product_engine

Overview:
Fixed-point tensor-by-matrix product engine: C[i][j][l] = sum over k of A[i][j][k]·B[k][l], for runtime sizes up to parametrised maxima. A and B are streamed into internal buffers, then a single MAC datapath produces C elements serially with index-boundary markers. It sits in the NTM algebra/tensor library and feeds controller and read/write-head datapaths.

Parameters:
DATA_SIZE, 16, element width (two's complement fixed point)
FRACTION_SIZE, 8, fractional bits of every element
MAX_I, 4, maximum I dimension
MAX_J, 4, maximum J dimension
MAX_K, 4, maximum K (contraction) dimension
MAX_L, 4, maximum L dimension

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-low reset
START  in  1  begin operation; sizes sampled on this cycle
READY  out  1  one-cycle pulse: operation complete
ERROR  out  1  one-cycle pulse: illegal size at START
SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, SIZE_L_IN  in  DATA_SIZE each  runtime dimensions
DATA_A_IN_ENABLE  in  1  DATA_A_IN valid
DATA_A_IN  in  DATA_SIZE  A element, order i,j,k (k fastest)
DATA_B_IN_ENABLE  in  1  DATA_B_IN valid
DATA_B_IN  in  DATA_SIZE  B element, order k,l (l fastest)
DATA_OUT_ENABLE  out  1  DATA_OUT valid
DATA_OUT_I_ENABLE  out  1  last element of whole tensor
DATA_OUT_J_ENABLE  out  1  last element of an i-slice (j,l wrap)
DATA_OUT_K_ENABLE  out  1  last element of a row (l wrap)
DATA_OUT  out  DATA_SIZE  C element, order i,j,l (l fastest)

Behaviour:
- Reset (RST=0, async): all outputs 0, FSM IDLE, counters and accumulator 0; buffer contents don't-care. Reset mid-operation aborts with no further output.
- States: IDLE, LOAD, COMPUTE, OUTPUT, DONE.
- IDLE: START=1 with every size in 1..MAX -> latch sizes, clear counters, go LOAD. Any size 0 or >MAX -> ERROR=1 next cycle, stay IDLE. START outside IDLE ignored.
- LOAD: each cycle an enabled A (resp. B) element is written at the A (resp. B) counter, which then increments; A and B may be enabled the same cycle. Enables after a counter reaches I·J·K (resp. K·L) are ignored. When both counts complete -> COMPUTE (cycle after last write).
- COMPUTE: accumulator cleared on entry; one k per cycle: acc += A[i][j][k]·B[k][l]; full-precision product 2·DATA_SIZE bits, accumulator 2·DATA_SIZE+clog2(MAX_K) bits. After K cycles -> OUTPUT.
- OUTPUT (1 cycle): DATA_OUT = acc arithmetic-right-shifted by FRACTION_SIZE, saturated to [most-negative, most-positive] DATA_SIZE value; DATA_OUT_ENABLE=1; K/J/I_ENABLE per markers above (all three high on last element). Advance l, wrap to j, wrap to i; next element -> COMPUTE, last -> DONE.
- DONE: READY=1 for one cycle -> IDLE.
- Per-element latency K+1 cycles; total after LOAD = I·J·L·(K+1)+1.
- All pulse outputs are registered and low outside their stated cycle; DATA_OUT holds its last value.

Decomposition:
- Shared package: FSM state encoding, ZERO/ONE constants, saturate function, index-width helpers.
- Sub-module accelerator_tensor_mac: signed multiply-accumulate with clear, enable and shift/saturate output; top keeps FSM, counters, buffers.

Test Plan:
- I=J=K=L=1, A=0x0200, B=0x0180 -> one output 0x0300 with all enables high; READY next cycle; 3 cycles from LOAD exit.
- I=J=1, K=L=2, A={0x0100,0x0200}, B={0x0100,0x0200,0x0300,0x0400} -> outputs 0x0700, 0x0A00; K_ENABLE on both, J/I_ENABLE on second only; A and B loaded simultaneously.
- K=1, A=0x7F00, B=0x7F00 -> 0x7FFF; A=0x8000, B=0x7F00 -> 0x8000 (saturation).
- START with SIZE_K_IN=0, then SIZE_L_IN=5 -> ERROR pulse each time, no READY, no DATA_OUT_ENABLE; next legal START works.
- Assert RST during COMPUTE of element 3 of a 2x2x2x2 run -> all outputs 0 immediately; after release a fresh run gives correct results.
- I=J=K=L=4, random values, gaps in enables and extra enables after full -> all 64 outputs match reference model, order and markers correct.
